// File: rtl/resp_signature_checker.sv
// Purpose: folds the wide y result bus into a MISR signature over a fixed sample run, then checks it against a golden value.
// Latency: one MISR step per accepted sample; a single COMPARE cycle after the last sample precedes done.
// Backpressure: none; y is sampled whenever y_valid is high in CAPTURE, and start is ignored while a run is in flight.
module resp_signature_checker #(
   parameter int unsigned         DATA_W      = 564,
   parameter int unsigned         SIG_W       = 32,
   parameter logic [SIG_W-1:0]    POLY        = 32'h04C11DB7,
   parameter logic [SIG_W-1:0]    SEED        = 32'hFFFFFFFF,
   parameter int unsigned         NUM_SAMPLES = 21,
   parameter int unsigned         CNT_W       = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic              y_valid,
   input  logic [DATA_W-1:0] y,
   input  logic [SIG_W-1:0]  exp_sig,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [SIG_W-1:0]  sig,
   output logic [CNT_W-1:0]  sample_cnt
);

   // y is zero-padded up to a whole number of signature lanes
   localparam int unsigned LANES = (DATA_W + SIG_W - 1) / SIG_W;
   localparam int unsigned PAD_W = LANES * SIG_W;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_COMPARE = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   state_t             state;
   logic [PAD_W-1:0]   y_pad;
   logic [SIG_W-1:0]   fold;
   logic [SIG_W-1:0]   misr_next;
   logic               last_sample;

   assign y_pad       = PAD_W'(y);
   assign last_sample = (sample_cnt == CNT_W'(NUM_SAMPLES - 1));

   // XOR all lanes of the padded bus, then advance the MISR by one step
   always_comb begin
      fold = '0;
      for (int i = 0; i < int'(LANES); i++) begin
         fold = fold ^ y_pad[i*SIG_W +: SIG_W];
      end
      misr_next = {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? POLY : '0) ^ fold;
   end

   // Run control: abort beats start beats sample capture; outputs are registered
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         sig        <= '0;
         sample_cnt <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
      end else if (abort) begin
         // sig and sample_cnt are left alone so a cancelled run can be inspected
         state <= ST_IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         pass  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state      <= ST_CAPTURE;
                  sig        <= SEED;
                  sample_cnt <= '0;
                  busy       <= 1'b1;
                  done       <= 1'b0;
                  pass       <= 1'b0;
               end
            end
            ST_CAPTURE: begin
               if (y_valid) begin
                  sig        <= misr_next;
                  sample_cnt <= sample_cnt + CNT_W'(1);
                  if (last_sample) begin
                     state <= ST_COMPARE;
                  end
               end
            end
            ST_COMPARE: begin
               pass  <= (sig == exp_sig);
               state <= ST_DONE;
               busy  <= 1'b0;
               done  <= 1'b1;
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
               pass  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_resp_signature_checker.sv
// Purpose: scoreboard bench for resp_signature_checker with a 21-sample instance and two 1-sample instances.
// Latency: results are popped from per-instance queues when done rises.
// Backpressure: stimulus never stalls; every wait on done is bounded.
module tb_resp_signature_checker;

   localparam int DW = 564;

   typedef struct {
      logic [31:0] sig;
      logic [7:0]  cnt;
      logic        pass;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   // 21-sample instance, SEED=0
   logic          l_start = 1'b0, l_abort = 1'b0, l_yv = 1'b0;
   logic [DW-1:0] l_y = '0;
   logic [31:0]   l_exp = '0;
   logic          l_busy, l_done, l_pass;
   logic [31:0]   l_sig;
   logic [7:0]    l_cnt;

   // two 1-sample instances sharing stimulus: SEED=0 and SEED=0x80000000
   logic          s_start = 1'b0, s_abort = 1'b0, s_yv = 1'b0;
   logic [DW-1:0] s_y = '0;
   logic [31:0]   s_exp = '0;
   logic          o_busy, o_done, o_pass, f_busy, f_done, f_pass;
   logic [31:0]   o_sig, f_sig;
   logic [7:0]    o_cnt, f_cnt;

   exp_t q_l[$];
   exp_t q_o[$];
   exp_t q_f[$];

   int total = 0;
   int bad   = 0;

   logic l_done_q = 1'b0, o_done_q = 1'b0, f_done_q = 1'b0;

   always #5 clk = ~clk;

   resp_signature_checker #(.DATA_W(DW), .SIG_W(32), .POLY(32'h04C11DB7), .SEED(32'h0),
                            .NUM_SAMPLES(21), .CNT_W(8)) u_long (
      .clk(clk), .rst(rst), .start(l_start), .abort(l_abort), .y_valid(l_yv), .y(l_y),
      .exp_sig(l_exp), .busy(l_busy), .done(l_done), .pass(l_pass), .sig(l_sig), .sample_cnt(l_cnt));

   resp_signature_checker #(.DATA_W(DW), .SIG_W(32), .POLY(32'h04C11DB7), .SEED(32'h0),
                            .NUM_SAMPLES(1), .CNT_W(8)) u_one (
      .clk(clk), .rst(rst), .start(s_start), .abort(s_abort), .y_valid(s_yv), .y(s_y),
      .exp_sig(s_exp), .busy(o_busy), .done(o_done), .pass(o_pass), .sig(o_sig), .sample_cnt(o_cnt));

   resp_signature_checker #(.DATA_W(DW), .SIG_W(32), .POLY(32'h04C11DB7), .SEED(32'h80000000),
                            .NUM_SAMPLES(1), .CNT_W(8)) u_fb (
      .clk(clk), .rst(rst), .start(s_start), .abort(s_abort), .y_valid(s_yv), .y(s_y),
      .exp_sig(s_exp), .busy(f_busy), .done(f_done), .pass(f_pass), .sig(f_sig), .sample_cnt(f_cnt));

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic cmp_result(input string name, input exp_t e, input logic [31:0] s,
                             input logic [7:0] c, input logic p);
      check({name, "_sig"},  64'(s), 64'(e.sig));
      check({name, "_cnt"},  64'(c), 64'(e.cnt));
      check({name, "_pass"}, 64'(p), 64'(e.pass));
   endtask

   task automatic unexpected(input string name);
      total++;
      bad++;
      $display("FAIL %s done with empty queue actual=1 required=0", name);
   endtask

   // Monitor: pop and compare on each rising done
   always @(negedge clk) begin
      if (l_done && !l_done_q) begin
         if (q_l.size() == 0) unexpected("long");
         else cmp_result("long", q_l.pop_front(), l_sig, l_cnt, l_pass);
      end
      if (o_done && !o_done_q) begin
         if (q_o.size() == 0) unexpected("one");
         else cmp_result("one", q_o.pop_front(), o_sig, o_cnt, o_pass);
      end
      if (f_done && !f_done_q) begin
         if (q_f.size() == 0) unexpected("fb");
         else cmp_result("fb", q_f.pop_front(), f_sig, f_cnt, f_pass);
      end
      l_done_q <= l_done;
      o_done_q <= o_done;
      f_done_q <= f_done;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic l_go();
      l_start = 1'b1;
      tick();
      l_start = 1'b0;
   endtask

   task automatic l_sample(input logic vld, input logic [DW-1:0] v);
      l_yv = vld;
      l_y  = v;
      tick();
      l_yv = 1'b0;
   endtask

   task automatic wait_done(input bit long_inst, input string name);
      int n = 0;
      while (!(long_inst ? l_done : o_done) && n < 20) begin
         tick();
         n++;
      end
      check({name, "_done_timeout"}, 64'(long_inst ? l_done : o_done), 64'd1);
      @(negedge clk);
      #1;
   endtask

   task automatic s_run(input logic [DW-1:0] v, input logic [31:0] ex, input string name);
      s_exp   = ex;
      s_start = 1'b1;
      tick();
      s_start = 1'b0;
      s_yv    = 1'b1;
      s_y     = v;
      tick();
      s_yv    = 1'b0;
      wait_done(1'b0, name);
   endtask

   logic [DW-1:0] v;

   initial begin
      // reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_l_busy", 64'(l_busy), 64'd0);
      check("rst_l_done", 64'(l_done), 64'd0);
      check("rst_l_pass", 64'(l_pass), 64'd0);
      check("rst_l_sig",  64'(l_sig),  64'd0);
      check("rst_l_cnt",  64'(l_cnt),  64'd0);
      check("rst_f_sig",  64'(f_sig),  64'd0);
      rst = 1'b0;
      tick();

      // T1: reset in the middle of a capture clears everything without a clock edge
      l_go();
      v = '0;
      v[3] = 1'b1;
      for (int i = 0; i < 3; i++) l_sample(1'b1, v);
      check("t1_cnt_before", 64'(l_cnt), 64'd3);
      check("t1_busy_before", 64'(l_busy), 64'd1);
      #2;
      rst = 1'b1;
      #1;
      check("t1_busy", 64'(l_busy), 64'd0);
      check("t1_sig",  64'(l_sig),  64'd0);
      check("t1_cnt",  64'(l_cnt),  64'd0);
      check("t1_done", 64'(l_done), 64'd0);
      tick();
      rst = 1'b0;
      // y_valid in IDLE is ignored
      l_sample(1'b1, v);
      check("idle_ignore_cnt", 64'(l_cnt), 64'd0);
      check("idle_ignore_sig", 64'(l_sig), 64'd0);

      // T2: zero stream
      q_l.push_back('{sig: 32'h0, cnt: 8'd21, pass: 1'b1});
      l_exp = 32'h0;
      l_go();
      for (int i = 0; i < 21; i++) l_sample(1'b1, '0);
      wait_done(1'b1, "t2");
      check("t2_pass_hold", 64'(l_pass), 64'd1);
      // abort in DONE clears pass/done
      l_abort = 1'b1;
      tick();
      l_abort = 1'b0;
      check("abort_done_pass", 64'(l_pass), 64'd0);
      check("abort_done_done", 64'(l_done), 64'd0);

      // feedback through 21 samples: high bit set by sample 20, folded in by sample 21
      q_l.push_back('{sig: 32'h04C11DB7, cnt: 8'd21, pass: 1'b1});
      l_exp = 32'h04C11DB7;
      l_go();
      for (int i = 0; i < 19; i++) l_sample(1'b1, '0);
      v = '0;
      v[31] = 1'b1;
      l_sample(1'b1, v);
      check("fb21_mid_sig", 64'(l_sig), 64'h80000000);
      l_sample(1'b1, '0);
      wait_done(1'b1, "fb21");

      // same stream restarted from DONE, wrong golden, start mid-run ignored
      q_l.push_back('{sig: 32'h04C11DB7, cnt: 8'd21, pass: 1'b0});
      l_exp = 32'h04C11DB6;
      l_go();
      for (int i = 0; i < 19; i++) begin
         l_start = (i == 5);
         l_sample(1'b1, '0);
         l_start = 1'b0;
      end
      l_sample(1'b1, v);
      l_sample(1'b1, '0);
      wait_done(1'b1, "fb21_bad");

      // T6: gaps then abort at sample 10
      l_go();
      v = '0;
      v[0] = 1'b1;
      l_sample(1'b1, v);
      for (int i = 1; i < 10; i++) begin
         l_sample(1'b0, '1);
         check("t6_gap_cnt", 64'(l_cnt), 64'(i));
         l_sample(1'b1, '0);
         check("t6_step_cnt", 64'(l_cnt), 64'(i + 1));
      end
      l_abort = 1'b1;
      l_yv    = 1'b1;
      tick();
      l_abort = 1'b0;
      l_yv    = 1'b0;
      check("t6_abort_busy", 64'(l_busy), 64'd0);
      check("t6_abort_cnt",  64'(l_cnt),  64'd10);
      check("t6_abort_sig",  64'(l_sig),  64'h200);
      check("t6_abort_pass", 64'(l_pass), 64'd0);
      l_sample(1'b1, v);
      check("t6_idle_cnt", 64'(l_cnt), 64'd10);
      l_go();
      check("t6_restart_sig",  64'(l_sig),  64'd0);
      check("t6_restart_cnt",  64'(l_cnt),  64'd0);
      check("t6_restart_busy", 64'(l_busy), 64'd1);
      l_abort = 1'b1;
      tick();
      l_abort = 1'b0;

      // T3/T4/T5 and lane edges on the single-sample instances
      v = '0; v[0] = 1'b1;
      q_o.push_back('{sig: 32'h1, cnt: 8'd1, pass: 1'b1});
      q_f.push_back('{sig: 32'h04C11DB6, cnt: 8'd1, pass: 1'b0});
      s_run(v, 32'h1, "t3a");
      q_o.push_back('{sig: 32'h1, cnt: 8'd1, pass: 1'b0});
      q_f.push_back('{sig: 32'h04C11DB6, cnt: 8'd1, pass: 1'b0});
      s_run(v, 32'h2, "t3b");
      v = '0; v[32] = 1'b1;
      q_o.push_back('{sig: 32'h1, cnt: 8'd1, pass: 1'b0});
      q_f.push_back('{sig: 32'h04C11DB6, cnt: 8'd1, pass: 1'b0});
      s_run(v, 32'h0, "t4a");
      v[0] = 1'b1;
      q_o.push_back('{sig: 32'h0, cnt: 8'd1, pass: 1'b1});
      q_f.push_back('{sig: 32'h04C11DB7, cnt: 8'd1, pass: 1'b0});
      s_run(v, 32'h0, "t4b");
      q_o.push_back('{sig: 32'h0, cnt: 8'd1, pass: 1'b0});
      q_f.push_back('{sig: 32'h04C11DB7, cnt: 8'd1, pass: 1'b1});
      s_run('0, 32'h04C11DB7, "t5");
      v = '0; v[DW-1] = 1'b1;
      q_o.push_back('{sig: 32'h00080000, cnt: 8'd1, pass: 1'b1});
      q_f.push_back('{sig: 32'h04C91DB7, cnt: 8'd1, pass: 1'b0});
      s_run(v, 32'h00080000, "top_lane");
      q_o.push_back('{sig: 32'hFFF00000, cnt: 8'd1, pass: 1'b1});
      q_f.push_back('{sig: 32'hFB311DB7, cnt: 8'd1, pass: 1'b0});
      s_run('1, 32'hFFF00000, "all_ones");

      repeat (3) tick();
      check("q_long_left", 64'(q_l.size()), 64'd0);
      check("q_one_left",  64'(q_o.size()), 64'd0);
      check("q_fb_left",   64'(q_f.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
